// File: rtl/wb_port_arbiter.sv
// Writeback port arbiter: merges ALU results and load returns onto the single
// register-file write port, tracks pending loads and bypasses the in-flight write.
module wb_port_arbiter #(
  parameter int unsigned MAX_PEND = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        alu_valid,
  input  logic [4:0]  alu_rd,
  input  logic [31:0] alu_data,
  input  logic        mem_valid,
  output logic        mem_ready,
  input  logic [4:0]  mem_rd,
  input  logic [31:0] mem_data,
  input  logic        iss_valid,
  input  logic [4:0]  iss_rd,
  output logic        iss_stall,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  output logic        hz1,
  output logic        hz2,
  output logic        byp1_valid,
  output logic        byp2_valid,
  output logic [31:0] byp1_data,
  output logic [31:0] byp2_data,
  output logic        w_en,
  output logic [4:0]  w_addr,
  output logic [31:0] w_data,
  output logic [4:0]  pend_cnt,
  output logic        err
);

  logic [31:0] busy_q, busy_d;
  logic [4:0]  pend_q, pend_d;
  logic        w_en_q, w_en_d;
  logic [4:0]  w_addr_q, w_addr_d;
  logic [31:0] w_data_q, w_data_d;
  logic        err_q, err_d;

  logic mem_acc;
  logic iss_acc;
  logic full;
  logic ret_same;
  logic dec_ok;

  assign mem_ready = !alu_valid;
  assign mem_acc   = mem_valid && !alu_valid;
  assign full      = (pend_q == 5'(MAX_PEND));
  // A same-cycle return to the issuing register frees it, so no WAW stall.
  assign ret_same  = mem_acc && (mem_rd == iss_rd);
  assign iss_stall = full || ((iss_rd != '0) && busy_q[iss_rd] && !ret_same);
  assign iss_acc   = iss_valid && !iss_stall;
  assign dec_ok    = mem_acc && (pend_q != '0);

  assign hz1        = busy_q[rs1];
  assign hz2        = busy_q[rs2];
  assign byp1_valid = w_en_q && (w_addr_q == rs1) && (rs1 != '0);
  assign byp2_valid = w_en_q && (w_addr_q == rs2) && (rs2 != '0);
  assign byp1_data  = w_data_q;
  assign byp2_data  = w_data_q;

  assign w_en     = w_en_q;
  assign w_addr   = w_addr_q;
  assign w_data   = w_data_q;
  assign pend_cnt = pend_q;
  assign err      = err_q;

  always_comb begin
    busy_d = busy_q;
    if (mem_acc) busy_d[mem_rd] = 1'b0;
    if (iss_acc && (iss_rd != '0)) busy_d[iss_rd] = 1'b1;
    busy_d[0] = 1'b0;

    pend_d = pend_q;
    if (iss_acc && !dec_ok)      pend_d = pend_q + 5'd1;
    else if (!iss_acc && dec_ok) pend_d = pend_q - 5'd1;

    err_d = err_q || (mem_acc && ((pend_q == '0) ||
                                  ((mem_rd != '0) && !busy_q[mem_rd])));

    w_en_d   = 1'b0;
    w_addr_d = w_addr_q;
    w_data_d = w_data_q;
    if (alu_valid) begin
      w_en_d   = (alu_rd != '0);
      w_addr_d = alu_rd;
      w_data_d = alu_data;
    end else if (mem_acc) begin
      w_en_d   = (mem_rd != '0);
      w_addr_d = mem_rd;
      w_data_d = mem_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q   <= '0;
      pend_q   <= '0;
      w_en_q   <= 1'b0;
      w_addr_q <= '0;
      w_data_q <= '0;
      err_q    <= 1'b0;
    end else begin
      busy_q   <= busy_d;
      pend_q   <= pend_d;
      w_en_q   <= w_en_d;
      w_addr_q <= w_addr_d;
      w_data_q <= w_data_d;
      err_q    <= err_d;
    end
  end

endmodule

// File: doc/wb_port_arbiter.md
# wb_port_arbiter

Writeback-side companion to the CPU register file. Merges single-cycle ALU results and multi-cycle load returns onto the register file's single write port (`w_en`/`w_addr`/`w_data`) through one registered stage. Keeps a pending-load scoreboard so decode can detect RAW/WAW hazards, and bypasses the in-flight write so reads never see stale data.

## Interface
- `MAX_PEND`, default 4: maximum number of outstanding loads, range 1–31.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `alu_valid`  in  1  ALU writeback request; always accepted.
- `alu_rd`  in  5  ALU destination register.
- `alu_data`  in  32  ALU result.
- `mem_valid`  in  1  load-return request.
- `mem_ready`  out  1  load return accepted this cycle.
- `mem_rd`  in  5  load destination register.
- `mem_data`  in  32  load data.
- `iss_valid`  in  1  decode issues a load this cycle.
- `iss_rd`  in  5  destination of the issued load.
- `iss_stall`  out  1  load issue refused this cycle.
- `rs1`, `rs2`  in  5 each  decode source addresses.
- `hz1`, `hz2`  out  1 each  source is awaiting a load.
- `byp1_valid`, `byp2_valid`  out  1 each  bypass data valid.
- `byp1_data`, `byp2_data`  out  32 each  bypass value, equal to `w_data`.
- `w_en`  out  1  register-file write enable (registered).
- `w_addr`  out  5  register-file write address (registered).
- `w_data`  out  32  register-file write data (registered).
- `pend_cnt`  out  5  outstanding load count.
- `err`  out  1  sticky protocol error.

## Operation
- Arbitration: ALU has fixed priority. `mem_ready = !alu_valid` (combinational). A load return is accepted when `mem_valid && mem_ready`.
- Write stage: on each edge, load the accepted request (ALU, else MEM) into `w_en`/`w_addr`/`w_data`.
  - If no request is accepted, `w_en` goes to 0 and `w_addr`/`w_data` hold their values.
  - A request with rd=0 is accepted but produces `w_en`=0.
- Scoreboard: 32-bit `busy` vector.
  - Bit 0 is always 0.
  - An accepted issue (`iss_valid && !iss_stall`) with `iss_rd`≠0 sets `busy[iss_rd]` and increments `pend_cnt`.
  - With `iss_rd`=0, the issue is counted but no busy bit is set.
  - An accepted MEM return clears `busy[mem_rd]` and decrements `pend_cnt`.
  - Issue and return in the same cycle: the count is unchanged. If the register is the same, the set wins and the bit stays 1.
- `iss_stall` is combinational. It is asserted when `pend_cnt==MAX_PEND`, or when `iss_rd`≠0 and `busy[iss_rd]` (WAW). An issue whose `iss_rd` equals an accepted `mem_rd` in the same cycle is not stalled.
- Hazards are combinational: `hzN = busy[rsN]` (0 for x0).
- Bypass is combinational: `bypN_valid = w_en && w_addr==rsN && rsN≠0`.
- `err` is set, and stays set until reset, on either of:
  - an accepted MEM return with `pend_cnt==0`;
  - an accepted MEM return whose `mem_rd`≠0 has `busy` clear.
  In both cases the write still proceeds and `pend_cnt` does not underflow.
- Reset, asynchronous: `busy`=0, `pend_cnt`=0, `w_en`=0, `w_addr`=0, `w_data`=0, `err`=0. Reset mid-operation discards the in-flight write and all pending state immediately.

## Timing
- Request accepted in cycle N → `w_en`/`w_addr`/`w_data` valid in cycle N+1 → register file updated at the N+2 edge.
- Bypass covers cycle N+1. From N+2 onward the register file read is correct.
- Scoreboard and `pend_cnt` update at the N→N+1 edge. `hz` drops in cycle N+1, the same cycle the bypass becomes valid.
- A MEM request stalled by `alu_valid` must hold its values. It is accepted in the first cycle `alu_valid`=0.
- Throughput: one write per cycle. There is no bubble between back-to-back requests.

## Test plan
- Reset: assert `rst_n`=0 mid-stream with `busy[5]` set → all outputs 0 in the same cycle. After release, `rs1`=5 gives `hz1`=0.
- ALU path: `alu_valid`, rd=3, data=0xDEADBEEF at cycle N → cycle N+1 shows `w_en`=1, `w_addr`=3, `w_data`=0xDEADBEEF, and with `rs2`=3, `byp2_valid`=1. ALU rd=0 → `w_en`=0.
- Load lifecycle: issue rd=7 → `hz1`=1 for `rs1`=7 and `pend_cnt`=1. Return rd=7, data=0x1234 → next cycle `hz1`=0, `byp1_data`=0x1234, `pend_cnt`=0.
- Contention: `alu_valid` and `mem_valid` together for 2 cycles → `mem_ready`=0. The ALU writes land first, then the MEM write one cycle after `alu_valid` drops.
- Stalls: issue 4 loads to x1–x4 with `MAX_PEND`=4 → 5th issue `iss_stall`=1. Issue to busy x2 → stall. Issue x2 with a same-cycle return x2 → accepted and `busy[2]` stays 1.
- Error: MEM return with `pend_cnt`=0 → `err`=1, write still occurs, `pend_cnt` stays 0, `err` persists until reset.
